// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch producer for the IF/ID pipeline register. Owns the fetch
// PC, keeps at most one request outstanding to instruction memory, and parks
// returned words in a small prefetch FIFO. This lets memory wait states and
// pipeline freezes decouple. The FIFO head is presented to the decode stage
// as {pc_out = address+4, instruction_out}, qualified by out_valid.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous reset, active low
//   freeze           consumer refuses the head entry this cycle
//   branch_taken     one-cycle redirect pulse from EX (highest priority)
//   branch_addr      redirect target, word aligned
//   mem_req          registered request valid (high while a request is out)
//   mem_addr         registered request address, stable while mem_req=1
//   mem_rdata        instruction word, sampled when mem_ready=1
//   mem_ready        outstanding request completes at this edge
//   pc_out           address+4 of the head entry
//   instruction_out  instruction of the head entry
//   out_valid        head entry valid (0 = bubble)
//   buf_count        prefetch buffer occupancy
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding
// BUSY  | request outstanding, returned word will be buffered
// DROP  | request outstanding, returned word will be discarded (after a
//       | redirect that arrived while memory was still busy)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_addr,
    output logic                       mem_req,
    output logic [31:0]                mem_addr,
    input  logic [31:0]                mem_rdata,
    input  logic                       mem_ready,
    output logic [31:0]                pc_out,
    output logic [31:0]                instruction_out,
    output logic                       out_valid,
    output logic [$clog2(BUF_DEPTH):0] buf_count
);

    localparam int            PW   = $clog2(BUF_DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_nxt;
    logic [31:0]   addr_nxt;
    logic [31:0]   ret_pc;

    logic [31:0]   buf_pc  [BUF_DEPTH];
    logic [31:0]   buf_ins [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    logic          push;
    logic          pop;
    logic          clear;
    logic          pending;

    // Address+4 of the word currently being fetched; wraps mod 2^32.
    assign ret_pc = mem_addr + 32'd4;

    // -----------------------------------------------------------------------
    // Next-state / datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        addr_nxt     = mem_addr;
        count_nxt    = count;
        push         = 1'b0;
        pop          = 1'b0;
        clear        = 1'b0;
        pending      = 1'b0;

        if (branch_taken) begin
            // Redirect wins over freeze, push and pop.
            clear        = 1'b1;
            count_nxt    = '0;
            fetch_pc_nxt = branch_addr;
            if ((state != IDLE) && !mem_ready) begin
                // Memory still owes us a word for the old path; it must be
                // swallowed before the new address can be presented.
                state_nxt = DROP;
            end else begin
                state_nxt = BUSY;
                addr_nxt  = branch_addr;
            end
        end else begin
            pop = out_valid && !freeze;

            case (state)
                BUSY: begin
                    pending = !mem_ready;
                    if (mem_ready) begin
                        push         = 1'b1;
                        fetch_pc_nxt = ret_pc;
                    end
                end
                DROP: begin
                    pending = !mem_ready;
                end
                default: begin
                    pending = 1'b0;
                end
            endcase

            count_nxt = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

            // Only issue when the word can be guaranteed a slot on return,
            // so the buffer cannot overflow.
            if (!pending) begin
                if (count_nxt < FULL) begin
                    state_nxt = BUSY;
                    addr_nxt  = fetch_pc_nxt;
                end else begin
                    state_nxt = IDLE;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State, fetch PC and request registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= RESET_PC;
            mem_req  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            mem_addr <= addr_nxt;
            mem_req  <= (state_nxt != IDLE);
        end
    end

    // -----------------------------------------------------------------------
    // Prefetch FIFO
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc[i]  <= '0;
                buf_ins[i] <= '0;
            end
        end else begin
            count <= count_nxt;
            if (clear) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    buf_pc[wr_ptr]  <= ret_pc;
                    buf_ins[wr_ptr] <= mem_rdata;
                    wr_ptr          <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Head of the FIFO; all sources are registers. Bubbles read as zero.
    assign out_valid       = (count != '0);
    assign pc_out          = out_valid ? buf_pc[rd_ptr]  : 32'd0;
    assign instruction_out = out_valid ? buf_ins[rd_ptr] : 32'd0;
    assign buf_count       = count;

    // The issue rule reserves a slot before requesting, so a push into a
    // full buffer indicates broken control logic.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        !(push && (count == FULL)));

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'd0;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     freeze;
    logic                     branch_taken;
    logic [31:0]              branch_addr;
    logic                     mem_req;
    logic [31:0]              mem_addr;
    logic [31:0]              mem_rdata;
    logic                     mem_ready;
    logic [31:0]              pc_out;
    logic [31:0]              instruction_out;
    logic                     out_valid;
    logic [$clog2(DEPTH):0]   buf_count;

    if_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .out_valid       (out_valid),
        .buf_count       (buf_count)
    );

    always #5 clk = ~clk;

    // Reference model: queue of delivered entries plus a request tracker.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    bit          m_out;
    bit          m_drop;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fpc  = RPC;
        m_addr = RPC;
        m_out  = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic model_edge(input bit fz, input bit br, input logic [31:0] ba,
                              input bit rdy, input logic [31:0] rd);
        bit   done;
        ent_t e;
        if (br) begin
            q.delete();
            m_fpc = ba;
            if (m_out && !rdy) begin
                m_drop = 1'b1;
            end else begin
                m_out  = 1'b1;
                m_drop = 1'b0;
                m_addr = ba;
            end
        end else begin
            done = m_out && rdy;
            if (q.size() > 0 && !fz) void'(q.pop_front());
            if (done && !m_drop) begin
                e.pc  = m_addr + 32'd4;
                e.ins = rd;
                q.push_back(e);
                m_fpc = m_addr + 32'd4;
            end
            if (done) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            if (!m_out && q.size() < DEPTH) begin
                m_out  = 1'b1;
                m_addr = m_fpc;
            end
        end
    endtask

    task automatic compare_all();
        chk("mem_req", 32'(mem_req), 32'(m_out));
        chk("mem_addr", mem_addr, m_addr);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("buf_count", 32'(buf_count), 32'(q.size()));
        if (q.size() != 0) begin
            chk("pc_out", pc_out, q[0].pc);
            chk("instruction_out", instruction_out, q[0].ins);
        end
    endtask

    // Called at a negedge: drive inputs, take one edge, compare at next negedge.
    task automatic step(input bit fz, input bit br, input logic [31:0] ba, input bit rdy);
        freeze       = fz;
        branch_taken = br;
        branch_addr  = ba;
        mem_ready    = rdy;
        mem_rdata    = rdy ? mem_f(m_addr) : $urandom();
        @(posedge clk);
        model_edge(fz, br, ba, rdy, mem_rdata);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        mem_ready    = 1'b0;
        mem_rdata    = '0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_addr", mem_addr, RPC);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_pc_out", pc_out, 32'd0);
            chk("rst_instr", instruction_out, 32'd0);
            chk("rst_buf_count", 32'(buf_count), 32'd0);
        end
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int pct;
        bit fz, br, rdy;
        logic [31:0] ba;

        rst = 1'b1;
        freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        do_reset();

        // Zero-wait stream: addresses 0,4,8,12; outputs follow one edge later.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            chk("stream_addr", mem_addr, 32'(i * 4));
            chk("stream_req", 32'(mem_req), 32'd1);
            if (i >= 1) begin
                chk("stream_valid", 32'(out_valid), 32'd1);
                chk("stream_pc", pc_out, 32'(i * 4));
                chk("stream_instr", instruction_out, mem_f(32'((i - 1) * 4)));
            end
        end

        // Memory ready only every third cycle.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'd0, (i % 3) == 2);

        // Freeze with zero-wait memory fills the buffer and stops fetching.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
        chk("freeze_count", 32'(buf_count), 32'd2);
        chk("freeze_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Branch while the request at 8 is still outstanding.
        do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("pre_branch_addr", mem_addr, 32'd8);
        step(1'b0, 1'b1, 32'h100, 1'b0);
        chk("drop_addr", mem_addr, 32'd8);
        chk("drop_req", 32'(mem_req), 32'd1);
        chk("drop_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("redirect_addr", mem_addr, 32'h100);
        chk("redirect_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("redirect_pc", pc_out, 32'h104);
        chk("redirect_out_valid", 32'(out_valid), 32'd1);

        // Branch coincident with mem_ready and freeze.
        step(1'b1, 1'b1, 32'h40, 1'b1);
        chk("coinc_count", 32'(buf_count), 32'd0);
        chk("coinc_valid", 32'(out_valid), 32'd0);
        chk("coinc_addr", mem_addr, 32'h40);
        chk("coinc_req", 32'(mem_req), 32'd1);

        // Address wrap at the top of the 32-bit space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_pc", pc_out, 32'd0);
        chk("wrap_addr", mem_addr, 32'd0);

        // Asynchronous reset while BUSY at 0x20.
        do_reset();
        n = 0;
        while (mem_addr != 32'h20 && n < 20) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            n++;
        end
        chk("reach_0x20", mem_addr, 32'h20);
        mem_ready = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("async_req", 32'(mem_req), 32'd0);
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_count", 32'(buf_count), 32'd0);
        chk("async_addr", mem_addr, RPC);
        model_reset();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("restart_addr", mem_addr, RPC);
        chk("restart_req", 32'(mem_req), 32'd1);

        // Randomised traffic with varying memory speed.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            case ((i / 500) % 3)
                0:       pct = 90;
                1:       pct = 50;
                default: pct = 20;
            endcase
            fz  = ($urandom_range(0, 9) < 3);
            br  = ($urandom_range(0, 19) == 0);
            ba  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            rdy = ($urandom_range(0, 99) < pct);
            step(fz, br, ba, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch producer that feeds the IF/ID pipeline register. Owns the fetch PC and a single-outstanding-request handshake to instruction memory. Keeps a small prefetch buffer so memory wait states and pipeline freezes decouple. Delivers {PC+4, instruction} pairs with a valid flag and honours freeze and branch redirect from later stages.

Parameters:
- RESET_PC, 32'd0, fetch address after reset.
- BUF_DEPTH, 2, prefetch buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hazard stall; the consumer does not accept the head entry this cycle.
- branch_taken  in  1  one-cycle redirect pulse from EX.
- branch_addr  in  32  redirect target, word aligned.
- mem_req  out  1  registered request valid.
- mem_addr  out  32  registered request address; stable while mem_req=1.
- mem_rdata  in  32  instruction word; valid when mem_ready=1.
- mem_ready  in  1  request completes at this clock edge.
- pc_out  out  32  address+4 of the head entry.
- instruction_out  out  32  instruction of the head entry.
- out_valid  out  1  head entry valid; 0 means bubble.
- buf_count  out  clog2(BUF_DEPTH)+1  buffer occupancy, for debug and coverage.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, fetch_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, buffer empty.
  - out_valid=0, pc_out=0, instruction_out=0, buf_count=0.
- States:
  - IDLE: no outstanding request.
  - BUSY: request outstanding; result will be kept.
  - DROP: request outstanding; result will be discarded.
- mem_req=1 exactly in BUSY and DROP. mem_addr changes only when a new request issues.
- Pop: occurs at the edge when out_valid=1 and freeze=0. The head advances; the next entry, or a bubble, appears the following cycle.
- Push: occurs in BUSY when mem_ready=1. Writes {mem_addr+4, mem_rdata} to the tail, then fetch_pc<=mem_addr+4.
- Issue rule: let c be the occupancy after this edge's push/pop.
  - A new request issues (next state BUSY, mem_addr<=next fetch_pc) iff no request remains outstanding and c<BUF_DEPTH.
  - Otherwise, from IDLE stay IDLE; from BUSY with mem_ready go to IDLE.
  - Back-to-back issue is allowed: with mem_ready held high, one instruction per cycle.
- Latency: first mem_req rises at the first edge after reset deassert. With mem_ready=1, out_valid rises one edge later.
- Output: pc_out, instruction_out and out_valid are the buffer head, driven from registers; no comb path from mem_rdata.
- Freeze: holds the head and all outputs; fetching continues until the buffer is full.
- Redirect (branch_taken=1 at an edge):
  - Highest priority; overrides freeze, push and pop.
  - Buffer cleared; out_valid=0 next cycle; fetch_pc<=branch_addr.
  - If a request is outstanding and mem_ready=0: go to DROP; mem_addr is unchanged.
  - If mem_ready=1 or no request is outstanding: any returned data is discarded and the next state is BUSY with mem_addr<=branch_addr.
- DROP:
  - Waits for mem_ready; data is discarded, then issues at fetch_pc (next state BUSY).
  - A second branch in DROP only updates fetch_pc.
- Wrap-around: fetch_pc and pc_out are computed mod 2^32; 32'hFFFFFFFC+4 yields 0.
- Buffer pointers wrap mod BUF_DEPTH. The buffer never overflows by construction; a push into a full buffer is an assertion failure.
- Reset mid-request: everything returns to reset values immediately. A late mem_ready after reset is ignored because state is IDLE.

Test Plan:
- Reset/stream: hold rst=0 for 3 cycles, then release with mem_ready=1 tied high.
  - During reset: all outputs are 0.
  - Expected: mem_addr 0,4,8 on consecutive cycles; out_valid high from the 2nd edge.
  - Expected: pc_out 4,8,12 with the matching instructions.
- Wait states: mem_ready high only every 3rd cycle.
  - mem_addr must be held stable while waiting.
  - out_valid shows bubbles between entries; no address is skipped or duplicated.
- Freeze with full buffer: zero-wait memory, freeze=1 for 5 cycles.
  - buf_count saturates at 2 and mem_req drops to 0.
  - pc_out stays constant.
  - After release, pc_out continues in order with no loss.
- Branch during wait: request at addr 8 outstanding, branch_taken with branch_addr=0x100, mem_ready arrives 2 cycles later.
  - Expected: DROP; out_valid=0; the addr-8 data is never output.
  - The next request is at 0x100; the first output is pc_out=0x104.
- Branch coincident with mem_ready and freeze: branch_taken=1, mem_ready=1, freeze=1 at the same edge with branch_addr=0x40.
  - Expected: buffer empty; returned data discarded.
  - mem_addr=0x40 issued next cycle.
- Async reset mid-request: assert rst=0 between edges while BUSY at addr 0x20.
  - Expected: mem_req=0 and out_valid=0 immediately.
  - After release, fetch restarts at RESET_PC.
